sha1_wsched: RTL and testbench

//  SHA-1 message-schedule stage, directly upstream of the per-round compression logic.

---
 rtl/sha1_pkg.sv | 18 +
 rtl/sha1_wsched_if.sv | 25 ++
 rtl/sha1_wsched_sr.sv | 29 ++
 rtl/sha1_wsched.sv | 100 ++++++++++
 tb/tb_sha1_wsched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and helpers for the schedule and round/compression stages.
package sha1_pkg;

  localparam int SHA1_ROUNDS = 80;

  typedef logic [31:0] sha1_word_t;
  typedef logic [6:0]  sha1_t_t;

  typedef enum logic {
    IDLE,
    EMIT
  } sha1_ws_state_e;

  function automatic sha1_word_t rotl1(input sha1_word_t x);
    return {x[30:0], x[31]};
  endfunction

endpackage

// File: rtl/sha1_wsched_if.sv
// Block-in / word-out stream bundle for the SHA-1 message-schedule stage.
interface sha1_wsched_if;
  import sha1_pkg::*;

  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk;
  logic         w_valid;
  logic         w_ready;
  sha1_word_t   w;
  sha1_t_t      t;
  logic         last;
  logic         busy;

  modport master (
    output blk_valid, blk, w_ready,
    input  blk_ready, w_valid, w, t, last, busy
  );

  modport slave (
    input  blk_valid, blk, w_ready,
    output blk_ready, w_valid, w, t, last, busy
  );

endinterface

// File: rtl/sha1_wsched_sr.sv
// 16-word schedule window: parallel load of a block, shift-by-one with the W[t+16] recurrence.
module sha1_wsched_sr
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] din,
  output sha1_word_t   head
);

  sha1_word_t sr [16];

  // NOTE: sr is a flop bank, not a RAM, so clearing it in reset is legal; never reset RAM-style arrays.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) sr[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) sr[i] <= din[511-32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
      sr[15] <= rotl1(sr[13] ^ sr[8] ^ sr[2] ^ sr[0]);
    end
  end

  assign head = sr[0];

endmodule

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: accepts a 512-bit block, streams W[0..79] tagged t=1..80.
// Optional SHA1_WSCHED_PRELOAD_EN adds a one-block holding register for zero-bubble streaming.
module sha1_wsched
  import sha1_pkg::*;
#(
  parameter int NROUNDS = SHA1_ROUNDS
) (
  input logic          clk,
  input logic          reset,
  sha1_wsched_if.slave s
);

  localparam sha1_t_t T_LAST = sha1_t_t'(NROUNDS);

  sha1_ws_state_e state;
  sha1_t_t        t_q;
  logic           last_q;
  logic           accept, fire, fire_last, sr_load;
  logic [511:0]   sr_din;
  sha1_word_t     head;

  assign fire      = (state == EMIT) && s.w_ready;
  assign fire_last = fire && last_q;
  assign accept    = s.blk_valid && s.blk_ready;

`ifdef SHA1_WSCHED_PRELOAD_EN
  logic [511:0] hold;
  logic         full;

  assign s.blk_ready = !reset && !full;
  // An accept that lands on the final beat with nothing held goes straight into sr.
  assign sr_load     = fire_last ? (full || accept) : (accept && state == IDLE);
  assign sr_din      = (fire_last && full) ? hold : s.blk;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else if (accept && state == EMIT && !fire_last) begin
      hold <= s.blk;
      full <= 1'b1;
    end else if (fire_last) begin
      full <= 1'b0;
    end
  end
`else
  assign s.blk_ready = !reset && (state == IDLE);
  assign sr_load     = accept;
  assign sr_din      = s.blk;
`endif

  // NOTE: state registers use <= so every flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      t_q    <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sr_load) begin
            state  <= EMIT;
            t_q    <= sha1_t_t'(1);
            last_q <= 1'b0;
          end
        end
        EMIT: begin
          if (fire_last) begin
            last_q <= 1'b0;
            if (sr_load) begin
              t_q <= sha1_t_t'(1);
            end else begin
              state <= IDLE;
              t_q   <= '0;
            end
          end else if (fire) begin
            t_q    <= t_q + sha1_t_t'(1);
            last_q <= (t_q == T_LAST - sha1_t_t'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sha1_wsched_sr u_sr (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (fire),
    .din   (sr_din),
    .head  (head)
  );

  assign s.w_valid = (state == EMIT);
  assign s.w       = head;
  assign s.t       = t_q;
  assign s.last    = last_q;
  assign s.busy    = (state != IDLE);

endmodule

// File: tb/tb_sha1_wsched.sv
// Self-checking bench for sha1_wsched: a queue of expected words built from the textbook
// W[t] recurrence is compared against the output stream on every cycle.
module tb_sha1_wsched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha1_wsched_if bus ();

  sha1_wsched #(.NROUNDS(80)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  bit          rand_rdy = 1'b0;
  logic [31:0] exp_q[$];
  int          exp_idx = 0;
  int          last_fire_cyc = -1;
  int          gap = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_w;
  logic [6:0]  prev_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Standard SHA-1 expansion: W[i] = ROTL1(W[i-3]^W[i-8]^W[i-14]^W[i-16]).
  function automatic logic [31:0] sched_word(input logic [511:0] b, input int n);
    logic [31:0] ws [80];
    logic [31:0] x;
    for (int i = 0; i < 16; i++) ws[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x     = ws[i-3] ^ ws[i-8] ^ ws[i-14] ^ ws[i-16];
      ws[i] = {x[30:0], x[31]};
    end
    return ws[n];
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // Consumer back-pressure driver.
  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.w_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: expected stream state lives entirely in exp_q / exp_idx.
  always @(negedge clk) begin
    if (reset) begin
      check("blk_ready_in_reset", 64'(bus.blk_ready), 64'(0));
      exp_q.delete();
      exp_idx       = 0;
      prev_stall    = 1'b0;
      last_fire_cyc = -1;
    end else begin
      logic have;
      have = (exp_q.size() != 0);
      check("w_valid", 64'(bus.w_valid), 64'(have));
      check("busy", 64'(bus.busy), 64'(have));
`ifdef SHA1_WSCHED_PRELOAD_EN
      check("blk_ready", 64'(bus.blk_ready), 64'(exp_q.size() <= 80));
`else
      check("blk_ready", 64'(bus.blk_ready), 64'(!have));
`endif
      if (bus.w_valid && have) begin
        check("w", 64'(bus.w), 64'(exp_q[0]));
        check("t", 64'(bus.t), 64'(exp_idx + 1));
        check("last", 64'(bus.last), 64'(exp_idx == 79));
        if (prev_stall) begin
          check("stall_w_stable", 64'(bus.w), 64'(prev_w));
          check("stall_t_stable", 64'(bus.t), 64'(prev_t));
        end
        if (exp_idx == 0 && last_fire_cyc >= 0) begin
          gap           = cyc - last_fire_cyc - 1;
          last_fire_cyc = -1;
        end
        if (bus.w_ready) begin
          if (exp_idx == 79) last_fire_cyc = cyc;
          void'(exp_q.pop_front());
          exp_idx = (exp_idx == 79) ? 0 : exp_idx + 1;
        end
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_w     = bus.w;
      prev_t     = bus.t;
      if (bus.blk_valid && bus.blk_ready)
        for (int n = 0; n < 80; n++) exp_q.push_back(sched_word(bus.blk, n));
    end
  end

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.blk_ready) break;
    end
    check({name, "_accept_timeout"}, 64'(k < 500), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Offer one block; after acceptance scramble blk so late changes must be ignored.
  task automatic send_block(input logic [511:0] b, input string name);
    bus.blk       = b;
    bus.blk_valid = 1'b1;
    wait_ready(name);
    bus.blk_valid = 1'b0;
    bus.blk       = rand_block();
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.w_valid) break;
    end
    check({name, "_drain_timeout"}, 64'(k < 2000), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, ones, blk_a, blk_b;
    int k;
    abc  = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    ones = '1;

    bus.blk_valid = 1'b0;
    bus.blk       = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_t", 64'(bus.t), 64'(0));
    check("rst_last", 64'(bus.last), 64'(0));
    check("rst_w_valid", 64'(bus.w_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_blk_ready", 64'(bus.blk_ready), 64'(1));

    // Hand-computed values that pin the model
    check("model_abc_w16", 64'(sched_word(abc, 16)), 64'h00000000C2C4C700);
    check("model_abc_w17", 64'(sched_word(abc, 17)), 64'h0);
    check("model_abc_w18", 64'(sched_word(abc, 18)), 64'h30);
    check("model_ones_w16", 64'(sched_word(ones, 16)), 64'h0);

    // 1: "abc", w_ready=1 -> 80 consecutive beats
    @(posedge clk); #1;
    send_block(abc, "t1");
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      check("t1_consec_valid", 64'(bus.w_valid), 64'(1));
      check("t1_consec_t", 64'(bus.t), 64'(i));
    end
    @(negedge clk);
    check("t1_idle_after", 64'(bus.w_valid), 64'(0));
    @(posedge clk); #1;

    // 2: same block under random back-pressure
    rand_rdy = 1'b1;
    send_block(abc, "t2");
    wait_idle("t2");
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // 3: reset in the t=37 cycle aborts the block
    send_block(rand_block(), "t3");
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.t == 7'd36) break;
    end
    check("t3_reach_t36", 64'(k < 200), 64'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t3_t_at_reset", 64'(bus.t), 64'(37));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t3_w_valid", 64'(bus.w_valid), 64'(0));
    check("t3_t", 64'(bus.t), 64'(0));
    check("t3_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    send_block(rand_block(), "t3_restart");
    wait_idle("t3");
    @(posedge clk); #1;

    // 4: back-to-back blocks with blk_valid held
    gap   = -1;
    blk_a = rand_block();
    blk_b = rand_block();
    bus.blk       = blk_a;
    bus.blk_valid = 1'b1;
    wait_ready("t4a");
    bus.blk = blk_b;
    wait_ready("t4b");
    bus.blk_valid = 1'b0;
    bus.blk       = rand_block();
    wait_idle("t4");
`ifdef SHA1_WSCHED_PRELOAD_EN
    check("t4_gap_zero", 64'(gap), 64'(0));
`else
    check("t4_gap_ge1", 64'(gap >= 1), 64'(1));
`endif
    @(posedge clk); #1;

    // 5: random blocks, random back-pressure, blk scrambled after each accept
    rand_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_block(rand_block(), "t5");
      wait_idle("t5");
      @(posedge clk); #1;
    end
    rand_rdy = 1'b0;

    // 6: all-ones block
    send_block(ones, "t6");
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.w_valid && bus.t == 7'd17) break;
    end
    check("t6_w16_lit", 64'(bus.w), 64'h0);
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
